// File: rtl/pixel_compositor.sv
`default_nettype none
// ============================================================================
// Module   : pixel_compositor
// Purpose  : Final video stage ahead of the VGA DAC. A 2-stage pipeline turns
//            game-object area flags into RGB: stage 1 resolves object
//            priority, stage 2 does the palette lookup, the end-of-game
//            effect and blank gating. Sync/blank are delayed by the same two
//            clocks. Also owns the end-of-game FSM (PLAY -> FLASH -> OVER).
// Ports    : clock, reset (async, active-low)
//            active_in, hs_in, vs_in, blank_n_in   - timing generator
//            ball, bar, lava, block_vis[NB-1:0]     - object area flags
//            endgame                                - game over request
//            vga_r/g/b[7:0], vga_hs, vga_vs, vga_blank_n - DAC pins
//            state_o[1:0]                           - 0 PLAY, 1 FLASH, 2 OVER
// Revision : 1.0 - initial release
// ============================================================================
module pixel_compositor #(
  parameter int NB           = 5,
  parameter int FLASH_FRAMES = 60,
  parameter int BLINK_BIT    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          active_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          blank_n_in,
  input  logic          ball,
  input  logic          bar,
  input  logic          lava,
  input  logic [NB-1:0] block_vis,
  input  logic          endgame,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_FLASH = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // Stage 1 stores a palette index rather than a raw object id: ball and bar
  // share white, and blocks 5..9 fold onto blocks 0..4.
  localparam logic [2:0] c_PAL_BG    = 3'd0;
  localparam logic [2:0] c_PAL_WHITE = 3'd1;
  localparam logic [2:0] c_PAL_LAVA  = 3'd2;
  localparam logic [2:0] c_PAL_BLK0  = 3'd3;
  localparam logic [7:0] c_LAST_FRAME = 8'(FLASH_FRAMES - 1);

  logic [2:0]  w_blk_pal;
  logic [2:0]  w_pal_s1;
  logic [2:0]  r_pal;
  logic        r_active;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank_n;
  logic [23:0] w_base;
  logic [23:0] w_fx;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_frame_cnt;
  logic [7:0]  w_frame_cnt_nxt;
  logic        r_endgame_q;
  logic        r_endgame_low_seen;
  logic        w_tick;
  logic        w_rise;

  // --------------------------------------------------------------------------
  // Stage 1: object priority
  // --------------------------------------------------------------------------
  // Scan from the top down so the lowest set block index is the one kept.
  always_comb begin
    w_blk_pal = c_PAL_BG;
    for (int i = NB - 1; i >= 0; i--) begin
      if (block_vis[i]) w_blk_pal = c_PAL_BLK0 + 3'(i % 5);
    end
  end

  always_comb begin
    w_pal_s1 = c_PAL_BG;
    if (ball)              w_pal_s1 = c_PAL_WHITE;
    else if (|block_vis)   w_pal_s1 = w_blk_pal;
    else if (lava && !bar) w_pal_s1 = c_PAL_LAVA;
    else if (bar)          w_pal_s1 = c_PAL_WHITE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pal     <= c_PAL_BG;
      r_active  <= 1'b0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_pal     <= w_pal_s1;
      r_active  <= active_in;
      r_hs      <= hs_in;
      r_vs      <= vs_in;
      r_blank_n <= blank_n_in;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: palette, end-of-game effect, blank gating
  // --------------------------------------------------------------------------
  always_comb begin
    case (r_pal)
      c_PAL_WHITE: w_base = 24'hFFFFFF;
      c_PAL_LAVA:  w_base = 24'hFF1919;
      3'd3:        w_base = 24'h0AE632;
      3'd4:        w_base = 24'h6432E6;
      3'd5:        w_base = 24'hC86432;
      3'd6:        w_base = 24'h32C864;
      3'd7:        w_base = 24'h6432C8;
      default:     w_base = 24'h000000;
    endcase

    w_fx = w_base;
    // 255 - c on an 8-bit channel is a bitwise invert.
    if (r_state == ST_FLASH && r_frame_cnt[BLINK_BIT])
      w_fx = ~w_base;
    else if (r_state == ST_OVER)
      w_fx = {1'b0, w_base[23:17], 1'b0, w_base[15:9], 1'b0, w_base[7:1]};

    if (!r_active) w_fx = 24'h000000;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_r       <= w_fx[23:16];
      vga_g       <= w_fx[15:8];
      vga_b       <= w_fx[7:0];
      vga_hs      <= r_hs;
      vga_vs      <= r_vs;
      vga_blank_n <= r_blank_n;
    end
  end

  // --------------------------------------------------------------------------
  // End-of-game FSM
  // --------------------------------------------------------------------------
  // Frame tick: the one-cycle-delayed vsync (r_vs) has just fallen; vga_vs
  // holds its previous value.
  assign w_tick = vga_vs & ~r_vs;

  // A rising edge needs endgame to have been seen low since reset, so a game
  // over held through reset does not re-trigger the flash.
  assign w_rise = endgame & ~r_endgame_q & r_endgame_low_seen;

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    if (!endgame) begin
      w_state_nxt     = ST_PLAY;
      w_frame_cnt_nxt = 8'd0;
    end else begin
      case (r_state)
        ST_PLAY: begin
          // A coincident frame tick is deliberately not counted.
          if (w_rise) begin
            w_state_nxt     = ST_FLASH;
            w_frame_cnt_nxt = 8'd0;
          end
        end
        ST_FLASH: begin
          if (w_tick) begin
            if (r_frame_cnt == c_LAST_FRAME) w_state_nxt = ST_OVER;
            else w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state            <= ST_PLAY;
      r_frame_cnt        <= 8'd0;
      r_endgame_q        <= 1'b0;
      r_endgame_low_seen <= 1'b0;
    end else begin
      r_state            <= w_state_nxt;
      r_frame_cnt        <= w_frame_cnt_nxt;
      r_endgame_q        <= endgame;
      if (!endgame) r_endgame_low_seen <= 1'b1;
    end
  end

  assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pixel_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_compositor
// Purpose  : Self-checking bench for pixel_compositor. Random pixel flags and
//            a short synthetic frame drive the DUT; a reference model derived
//            from the colour/priority/FSM rules pushes expected outputs into
//            a queue that a separate monitor pops and compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_compositor;

  localparam int NB       = 5;
  localparam int FF       = 20;
  localparam int BB       = 3;
  localparam int FRAME_LEN = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          active_in = 1'b0;
  logic          hs_in = 1'b1;
  logic          vs_in = 1'b1;
  logic          blank_n_in = 1'b0;
  logic          ball = 1'b0;
  logic          bar = 1'b0;
  logic          lava = 1'b0;
  logic [NB-1:0] block_vis = '0;
  logic          endgame = 1'b0;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, vga_blank_n;
  logic [1:0]    state_o;

  pixel_compositor #(.NB(NB), .FLASH_FRAMES(FF), .BLINK_BIT(BB)) dut (
    .clock       (clock),
    .reset       (reset),
    .active_in   (active_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .blank_n_in  (blank_n_in),
    .ball        (ball),
    .bar         (bar),
    .lava        (lava),
    .block_vis   (block_vis),
    .endgame     (endgame),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .state_o     (state_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [23:0] pal_blk [0:4] = '{24'h0AE632, 24'h6432E6, 24'hC86432,
                                 24'h32C864, 24'h6432C8};

  // ---------------- reference model ----------------
  function automatic logic [23:0] ref_colour(logic b, logic br, logic lv,
                                             logic [NB-1:0] bv);
    logic [23:0] c;
    bit          found;
    c = 24'h000000;
    found = 0;
    if (b) begin
      c = 24'hFFFFFF;
      found = 1;
    end
    for (int i = 0; i < NB; i++) begin
      if (!found && bv[i]) begin
        c = pal_blk[i % 5];
        found = 1;
      end
    end
    if (!found && lv && !br) begin
      c = 24'hFF1919;
      found = 1;
    end
    if (!found && br) c = 24'hFFFFFF;
    return c;
  endfunction

  function automatic logic [23:0] apply_effect(logic [23:0] c, int st, int cnt);
    logic [23:0] r;
    int ch;
    r = c;
    for (int k = 0; k < 3; k++) begin
      ch = int'(c[8*k +: 8]);
      if (st == 1 && ((cnt >> BB) & 1) == 1) ch = 255 - ch;
      else if (st == 2) ch = ch / 2;
      r[8*k +: 8] = 8'(ch);
    end
    return r;
  endfunction

  int          m_st, m_cnt, m_eg_last;
  bit          m_vs1, m_vs2, m_tick, m_rise;
  logic [23:0] p_rgb;
  bit          p_act, p_hs, p_vs, p_bl;
  exp_t        m_e;

  always @(posedge clock) begin
    if (!reset) begin
      m_st = 0; m_cnt = 0; m_eg_last = -1; m_vs1 = 1; m_vs2 = 1;
      p_rgb = 24'h0; p_act = 0; p_hs = 1; p_vs = 1; p_bl = 0;
      exp_q.delete();
    end else begin
      // Pixel leaving stage 2 now sees the state as it was before this edge.
      m_e.rgb = p_act ? apply_effect(p_rgb, m_st, m_cnt) : 24'h0;
      m_e.hs  = p_hs;
      m_e.vs  = p_vs;
      m_e.bl  = p_bl;
      m_tick  = m_vs2 && !m_vs1;
      m_rise  = endgame && (m_eg_last == 0);
      if (!endgame) begin
        m_st = 0; m_cnt = 0;
      end else if (m_st == 0) begin
        if (m_rise) begin m_st = 1; m_cnt = 0; end
      end else if (m_st == 1 && m_tick) begin
        if (m_cnt == FF - 1) m_st = 2;
        else m_cnt = m_cnt + 1;
      end
      m_e.st = 2'(m_st);
      exp_q.push_back(m_e);
      m_eg_last = endgame ? 1 : 0;
      m_vs2 = m_vs1;
      m_vs1 = vs_in;
      p_rgb = ref_colour(ball, bar, lava, block_vis);
      p_act = active_in; p_hs = hs_in; p_vs = vs_in; p_bl = blank_n_in;
    end
  end

  // ---------------- checking ----------------
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  exp_t mon_e;
  always @(negedge clock) begin
    if (reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(mon_e.rgb));
      check("sync", 32'({vga_hs, vga_vs, vga_blank_n}),
            32'({mon_e.hs, mon_e.vs, mon_e.bl}));
      check("state", 32'(state_o), 32'(mon_e.st));
    end
  end

  // ---------------- stimulus ----------------
  int fpos = 0;

  task automatic step(int n, bit rnd);
    repeat (n) begin
      @(negedge clock);
      fpos = (fpos + 1) % FRAME_LEN;
      vs_in = (fpos < 2) ? 1'b0 : 1'b1;
      if (rnd) begin
        active_in  = ($urandom_range(0, 4) != 0);
        ball       = ($urandom_range(0, 7) == 0);
        bar        = ($urandom_range(0, 3) == 0);
        lava       = ($urandom_range(0, 2) == 0);
        block_vis  = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom);
        hs_in      = 1'($urandom);
        blank_n_in = 1'($urandom);
      end
    end
  endtask

  task automatic px(logic a, logic b, logic br, logic lv, logic [NB-1:0] bv);
    step(1, 0);
    active_in = a; ball = b; bar = br; lava = lv; block_vis = bv;
  endtask

  task automatic check_reset_outputs();
    check("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("reset_sync", 32'({vga_hs, vga_vs, vga_blank_n}), 32'h6);
    check("reset_state", 32'(state_o), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    #1 check_reset_outputs();
    @(negedge clock);
    #2 reset = 1'b1;

    // Priority and blanking, directed
    blank_n_in = 1'b1;
    px(1, 1, 0, 1, 5'b00100);
    px(1, 0, 0, 1, 5'b00100);
    px(1, 0, 1, 1, 5'b00000);
    px(1, 0, 0, 1, 5'b00000);
    px(1, 0, 0, 0, 5'b10000);
    px(0, 1, 0, 0, 5'b00000);
    hs_in = 1'b0;
    px(1, 0, 0, 0, 5'b00001);
    blank_n_in = 1'b0;
    step(3, 0);

    // Random play
    step(150, 1);

    // Full flash run into OVER
    endgame = 1'b1;
    step(3, 1);
    check("enter_flash", 32'(state_o), 32'd1);
    step(FF * FRAME_LEN + 80, 1);
    check("reach_over", 32'(state_o), 32'd2);
    step(30, 1);

    // Restart, then repeated game-overs at random frame phases
    endgame = 1'b0;
    step(2, 1);
    check("restart_play", 32'(state_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      endgame = 1'b1;
      step($urandom_range(20, 60), 1);
      endgame = 1'b0;
      step($urandom_range(1, 20), 1);
    end

    // Reset in the middle of a flash with endgame held high
    endgame = 1'b1;
    step(60, 1);
    check("flash_before_reset", 32'(state_o), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    step(100, 1);
    check("held_endgame_stays_play", 32'(state_o), 32'd0);
    step(3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
